decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
//  RV32I decode/operand-fetch pipeline stage directly upstream of the combinational ALU.
//  Accepts fetched instructions (+PC) over valid/ready, reads the internal 32x32 register
//  file, decodes ALU-class ops into (a, b, AluFunc, rd, we), and holds them in an output
//  pipeline register. Writeback drives the register file write port from downstream.
// PARAMETERS
//  XLEN       32   datapath width; only 32 supported
//  NUM_REGS   32   architectural registers; x0 hardwired zero
// PORTS
//  clk_in        in   1   system clock
//  rst_in        in   1   synchronous, active-high reset
//  instr_in      in   32  fetched instruction word
//  pc_in         in   32  PC of instr_in
//  in_valid_in   in   1   instr_in/pc_in valid
//  in_ready_out  out  1   stage can accept this cycle
//  wb_en_in      in   1   register file write enable (from writeback)
//  wb_rd_in      in   5   write address
//  wb_data_in    in   32  write data
//  a_out         out  32  ALU operand a
//  b_out         out  32  ALU operand b
//  func_out      out  4   AluFunc: ADD0 SUB1 AND2 OR3 XOR4 SLT5 SLTU6 SLL7 SRL8 SRA9
//  rd_out        out  5   destination register
//  we_out        out  1   result must be written back
//  illegal_out   out  1   instruction not supported by this stage
//  out_valid_out out  1   output register holds a decoded instruction
//  out_ready_in  in   1   downstream consumes this cycle
// BEHAVIOUR
//  - Reset: out_valid_out=0, a/b/rd/func=0, we=0, illegal=0; all registers cleared to 0.
//    Reset has priority over any transfer or writeback in the same cycle; in-flight op is dropped.
//  - Handshake: in_ready_out = !out_valid_out || out_ready_in (combinational). Accept when
//    in_valid_in && in_ready_out; decoded result registered, visible next cycle (latency 1).
//    If out_valid_out && !out_ready_in, all outputs hold stable. Consumed with no new
//    accept -> out_valid_out=0 next cycle. Simultaneous consume+accept -> stays 1, new data.
//  - Decode (opcode[6:0]):
//    OP 0110011: a=rs1, b=rs2; funct3/funct7[5] -> ADD/SUB,SLL,SLT,SLTU,XOR,SRL/SRA,OR,AND.
//    OP-IMM 0010011: a=rs1, b=sext(imm[31:20]); SLLI/SRLI/SRAI b={27'b0,shamt}.
//    LUI 0110111: a=0, b={imm[31:12],12'b0}, ADD.  AUIPC 0010111: a=pc_in, b=U-imm, ADD.
//    we_out=1 and illegal_out=0 for those four. Any other opcode, or an invalid
//    funct7 on OP/shift-imm -> illegal_out=1, we_out=0, func=ADD, a=b=0, rd=instr[11:7].
//  - Register file: read combinationally at accept; x0 reads 0; writes to x0 ignored.
//    Write occurs at clock edge when wb_en_in. Same-cycle bypass: if wb_en_in && wb_rd_in!=0
//    && wb_rd_in==rs, the operand takes wb_data_in.
//  - No hazard detection beyond the bypass; the pipeline controller stalls via out_ready_in.
//  - Arithmetic: immediates sign-extended from bit 31; pc passed unmodified.
// TESTING
//  1 addi x1,x0,5 (0x00500093) -> next cycle valid, a=0, b=5, func=ADD, rd=1, we=1.
//  2 wb x2=0xDEADBEEF, then add x3,x2,x2 (0x002101B3) -> a=b=0xDEADBEEF, rd=3;
//    repeat with wb in same cycle as accept -> bypass gives identical result.
//  3 wb x0=0x1234 then add x3,x0,x0 -> a=b=0; srai x5,x6,3 (0x40335293) -> func=SRA, b=3.
//  4 lui x7,0x12345 (0x123453B7) -> a=0, b=0x12345000; auipc pc=0x100 -> a=0x100.
//  5 beq (0x00000063) -> illegal=1, we=0; out_ready_in=0 for 3 cycles -> outputs
//    stable, in_ready_out=0; release -> in_ready_out=1 same cycle.
//  6 assert rst_in while out_valid_out=1 with a simultaneous accept -> next cycle
//    out_valid_out=0, all outputs 0, register x2 reads 0.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode / operand-fetch stage: register file, ALU-class decode and a
// single output pipeline register feeding the combinational ALU.
module decode_stage #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            in_valid_in,
    output logic            in_ready_out,
    input  logic            wb_en_in,
    input  logic [4:0]      wb_rd_in,
    input  logic [XLEN-1:0] wb_data_in,
    output logic [XLEN-1:0] a_out,
    output logic [XLEN-1:0] b_out,
    output logic [3:0]      func_out,
    output logic [4:0]      rd_out,
    output logic            we_out,
    output logic            illegal_out,
    output logic            out_valid_out,
    input  logic            out_ready_in
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_func_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opcode = instr_in[6:0];
    assign rd     = instr_in[11:7];
    assign funct3 = instr_in[14:12];
    assign rs1    = instr_in[19:15];
    assign rs2    = instr_in[24:20];
    assign funct7 = instr_in[31:25];

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [XLEN-1:0] regs [NUM_REGS];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // NOTE: the whole array is cleared because software may rely on every
            // register reading zero after reset; this costs a reset net per flop.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en_in && wb_rd_in != 5'd0) begin
            // NOTE: state is always updated with <= so every reader sees the
            // pre-edge value regardless of process ordering.
            regs[wb_rd_in] <= wb_data_in;
        end
    end

    // Operand read with same-cycle writeback bypass; x0 is always zero.
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0) begin
            rs1_val = (wb_en_in && wb_rd_in == rs1) ? wb_data_in : regs[rs1];
        end
        if (rs2 != 5'd0) begin
            rs2_val = (wb_en_in && wb_rd_in == rs2) ? wb_data_in : regs[rs2];
        end
    end

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;

    assign imm_i = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
    assign imm_u = {instr_in[31:12], 12'b0};
    assign shamt = {{(XLEN-5){1'b0}}, instr_in[24:20]};

    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    alu_func_e       dec_func;
    logic            dec_legal;

    always_comb begin
        dec_a     = '0;
        dec_b     = '0;
        dec_func  = ALU_ADD;
        dec_legal = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                dec_a     = rs1_val;
                dec_b     = rs2_val;
                dec_legal = (funct7 == F7_BASE);
                unique case (funct3)
                    3'b000: begin
                        dec_func  = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                        dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                    3'b001: dec_func = ALU_SLL;
                    3'b010: dec_func = ALU_SLT;
                    3'b011: dec_func = ALU_SLTU;
                    3'b100: dec_func = ALU_XOR;
                    3'b101: begin
                        dec_func  = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                    3'b110: dec_func = ALU_OR;
                    default: dec_func = ALU_AND;
                endcase
            end
            OPC_OP_IMM: begin
                dec_a     = rs1_val;
                dec_b     = imm_i;
                dec_legal = 1'b1;
                unique case (funct3)
                    3'b000: dec_func = ALU_ADD;
                    3'b001: begin
                        dec_func  = ALU_SLL;
                        dec_b     = shamt;
                        dec_legal = (funct7 == F7_BASE);
                    end
                    3'b010: dec_func = ALU_SLT;
                    3'b011: dec_func = ALU_SLTU;
                    3'b100: dec_func = ALU_XOR;
                    3'b101: begin
                        dec_func  = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        dec_b     = shamt;
                        dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                    3'b110: dec_func = ALU_OR;
                    default: dec_func = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                dec_b     = imm_u;
                dec_legal = 1'b1;
            end
            OPC_AUIPC: begin
                dec_a     = pc_in;
                dec_b     = imm_u;
                dec_legal = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase

        // Unsupported encodings present a harmless ADD 0,0 downstream.
        if (!dec_legal) begin
            dec_a    = '0;
            dec_b    = '0;
            dec_func = ALU_ADD;
        end
    end

    // ------------------------------------------------------------------
    // Output pipeline register and handshake
    // ------------------------------------------------------------------
    logic accept;

    assign in_ready_out = !out_valid_out || out_ready_in;
    assign accept       = in_valid_in && in_ready_out;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            out_valid_out <= 1'b0;
            a_out         <= '0;
            b_out         <= '0;
            func_out      <= 4'd0;
            rd_out        <= 5'd0;
            we_out        <= 1'b0;
            illegal_out   <= 1'b0;
        end else if (accept) begin
            out_valid_out <= 1'b1;
            a_out         <= dec_a;
            b_out         <= dec_b;
            func_out      <= dec_func;
            rd_out        <= rd;
            we_out        <= dec_legal;
            illegal_out   <= !dec_legal;
        end else if (out_ready_in) begin
            out_valid_out <= 1'b0;
        end
    end

endmodule
